// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared widths, constants and state encoding for the instruction fetch
//   stage and its fetch buffer.
//   WordWidth        : address / PC width in bits
//   InstructionWidth : instruction word width in bits
//   PcIncrement      : byte distance between sequential instructions
//   EntryWidth       : width of one buffered entry {abort, pc, instr}
//   if_state_e       : request FSM states (IF_REQ_IDLE, IF_REQ, IF_WAIT)
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int WordWidth        = 32;
  localparam int InstructionWidth = 32;
  localparam int PcIncrement      = 4;
  localparam int EntryWidth       = 1 + WordWidth + InstructionWidth;

  typedef enum logic [1:0] {
    IF_REQ_IDLE = 2'd0,
    IF_REQ      = 2'd1,
    IF_WAIT     = 2'd2
  } if_state_e;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [WordWidth-1:0] word_align(input logic [WordWidth-1:0] addr);
    return addr & ~WordWidth'(3);
  endfunction

endpackage

// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Small synchronous FIFO holding fetched entries on their way to decode.
//   The head entry is presented combinationally; a flush empties the FIFO
//   and takes priority over any push or pop in the same cycle.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     flush      : discard every entry (push/pop of this cycle ignored)
//     push, wdata: write one entry at the tail
//     pop        : remove the head entry
//     rdata      : head entry (all zero while empty)
//     valid      : FIFO holds at least one entry
//     count      : number of entries currently held
// -----------------------------------------------------------------------------
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] entry [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && valid;

  // Zero the head while empty so stale storage never reaches decode.
  assign rdata = valid ? entry[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: contents are only observable through valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) entry[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage: generates the PC, issues one word read at a time
//   on the instruction memory request/response interface, buffers returned
//   words and hands {instr, pc, abort} to decode over valid/ready. A redirect
//   from execute flushes the buffer, reloads the PC and drops the response of
//   any request that was in flight.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     imem_req/addr   : read request and word-aligned byte address
//     imem_gnt        : request accepted (handshake with imem_req)
//     imem_rvalid     : one in-order response per granted request
//     imem_rdata/err  : response word and bus fault flag
//     redirect_valid  : load redirect_pc (low two bits ignored)
//     if_valid/ready  : handshake toward decode
//     if_instr/pc     : head instruction and its address
//     if_abort        : head entry carried a bus fault (if_instr is zero)
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [WordWidth-1:0] RESET_PC  = 32'h0000_0000,
  parameter int                   BUF_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        imem_req,
  output logic [WordWidth-1:0]        imem_addr,
  input  logic                        imem_gnt,
  input  logic                        imem_rvalid,
  input  logic [InstructionWidth-1:0] imem_rdata,
  input  logic                        imem_err,
  input  logic                        redirect_valid,
  input  logic [WordWidth-1:0]        redirect_pc,
  output logic                        if_valid,
  input  logic                        if_ready,
  output logic [InstructionWidth-1:0] if_instr,
  output logic [WordWidth-1:0]        if_pc,
  output logic                        if_abort
);

  localparam int CntW = $clog2(BUF_DEPTH) + 1;

  if_state_e                state;
  if_state_e                state_next;
  logic [WordWidth-1:0]     fetch_pc;
  logic [WordWidth-1:0]     fetch_pc_next;
  logic [WordWidth-1:0]     inflight_pc;
  logic                     discard;
  logic                     discard_next;

  logic [CntW-1:0]          buf_count;
  logic [CntW-1:0]          count_after;
  logic                     space_now;
  logic                     space_after;
  logic                     granted;
  logic                     push;
  logic                     pop;
  logic [EntryWidth-1:0]    push_entry;
  logic [EntryWidth-1:0]    head_entry;

  assign imem_addr = fetch_pc;
  assign granted   = (state == IF_REQ) && imem_gnt;

  // A redirect drops the response arriving with it and any pop offered by decode.
  assign push = (state == IF_WAIT) && imem_rvalid && !discard && !redirect_valid;
  assign pop  = if_valid && if_ready && !redirect_valid;

  // A faulting fetch is buffered with a zeroed instruction and the abort flag.
  assign push_entry = {imem_err, inflight_pc,
                       imem_err ? {InstructionWidth{1'b0}} : imem_rdata};

  // Occupancy once this cycle's push/pop have landed; no request is in flight
  // at that point because space is only re-evaluated as a response retires.
  always_comb begin
    count_after = buf_count;
    if (push) count_after = count_after + CntW'(1);
    if (pop)  count_after = count_after - CntW'(1);
  end

  assign space_now   = (buf_count < CntW'(BUF_DEPTH));
  assign space_after = (count_after < CntW'(BUF_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IF_REQ_IDLE;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      discard     <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      discard  <= discard_next;
      if (granted) inflight_pc <= fetch_pc;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    discard_next  = discard;
    imem_req      = 1'b0;

    case (state)
      IF_REQ_IDLE: begin
        if (space_now) state_next = IF_REQ;
      end
      IF_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          fetch_pc_next = fetch_pc + WordWidth'(PcIncrement);
          state_next    = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (imem_rvalid) begin
          discard_next = 1'b0;
          state_next   = space_after ? IF_REQ : IF_REQ_IDLE;
        end
      end
      default: state_next = IF_REQ_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_next = word_align(redirect_pc);
      // Only one request can be outstanding, so a single flag is enough to
      // swallow its response.
      discard_next  = ((state == IF_WAIT) && !imem_rvalid) || granted;
      case (state)
        IF_REQ_IDLE: state_next = IF_REQ;
        // An ungranted request is withdrawn for a cycle before the target is
        // issued. A request granted in this very cycle is already on the bus,
        // so wait for (and drop) its response rather than issue a second one.
        IF_REQ:      state_next = imem_gnt ? IF_WAIT : IF_REQ_IDLE;
        // The buffer is flushed, so there is room for the target right away.
        IF_WAIT:     state_next = imem_rvalid ? IF_REQ : IF_WAIT;
        default:     state_next = IF_REQ_IDLE;
      endcase
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (EntryWidth),
    .CW    (CntW)
  ) u_fetch_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .valid (if_valid),
    .count (buf_count)
  );

  assign if_abort = head_entry[EntryWidth-1];
  assign if_pc    = head_entry[EntryWidth-2 -: WordWidth];
  assign if_instr = head_entry[InstructionWidth-1:0];

`ifndef SYNTHESIS
  // A response to a request issued before reset may still trickle in after
  // release; tolerate responses until the first post-reset grant.
  logic stale_window;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     stale_window <= 1'b1;
    else if (imem_req && imem_gnt)  stale_window <= 1'b0;
  end

  // Responses are only legal while a request is outstanding.
  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (state != IF_WAIT) && !stale_window));
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_abort;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_abort       (if_abort)
  );

  int total = 0;
  int bad   = 0;

  // memory model state
  int          gnt_delay;
  int          rv_delay;
  int          wcnt;
  int          resp_cnt;
  bit          resp_pend;
  logic [31:0] resp_addr;
  bit          gnt_now;
  logic [31:0] gnt_addr;
  bit          err_en;
  logic [31:0] err_addr;
  int          n_gnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then drive memory inputs for the
  // following rising edge. Outputs are sampled by callers at this point.
  task automatic tick();
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    imem_rdata  = 32'h0;
    gnt_now     = 1'b0;
    if (resp_pend) begin
      if (resp_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = resp_addr ^ 32'hE000_0000;
        imem_err    = err_en && (resp_addr == err_addr);
        resp_pend   = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
    if (imem_req === 1'b1 && rst_n === 1'b1) begin
      if (wcnt >= gnt_delay) begin
        imem_gnt  = 1'b1;
        gnt_now   = 1'b1;
        gnt_addr  = imem_addr;
        resp_addr = imem_addr;
        resp_pend = 1'b1;
        resp_cnt  = rv_delay;
        n_gnt++;
        wcnt      = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_err       = 1'b0;
    imem_rdata     = 32'h0;
    resp_pend      = 1'b0;
    wcnt           = 0;
    n_gnt          = 0;
    err_en         = 1'b0;
    err_addr       = 32'h0;
    gnt_delay      = 0;
    rv_delay       = 1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a valid entry, check it, then let it be consumed.
  task automatic expect_entry(input string tag, input logic [31:0] pc, input logic ab);
    int n = 0;
    while (if_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'h0, if_valid}, 32'h1);
    chk({tag, "_pc"},    if_pc, pc);
    chk({tag, "_instr"}, if_instr, ab ? 32'h0 : (pc ^ 32'hE000_0000));
    chk({tag, "_abort"}, {31'h0, if_abort}, {31'h0, ab});
    $display("entry %s: pc=%h instr=%h abort=%0d", tag, if_pc, if_instr, if_abort);
    tick();
  endtask

  task automatic find_grant(input string tag, input logic [31:0] addr);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(gnt_now && gnt_addr == addr) && n < 40);
    chk(tag, {31'h0, gnt_now && (gnt_addr == addr)}, 32'h1);
  endtask

  initial begin
    // ---------------- 1: reset values and streaming ----------------
    rst_n = 1'b0;
    do_reset();
    rst_n = 1'b0;
    chk("t1_rst_req",    {31'h0, imem_req}, 32'h0);
    chk("t1_rst_addr",   imem_addr, 32'h0);
    chk("t1_rst_valid",  {31'h0, if_valid}, 32'h0);
    chk("t1_rst_instr",  if_instr, 32'h0);
    chk("t1_rst_pc",     if_pc, 32'h0);
    chk("t1_rst_abort",  {31'h0, if_abort}, 32'h0);
    if_ready = 1'b1;
    rst_n    = 1'b1;
    tick();
    chk("t1_req_after_release", {31'h0, imem_req}, 32'h1);
    chk("t1_first_gnt", {31'h0, gnt_now}, 32'h1);
    tick();
    chk("t1_valid_grant_plus1", {31'h0, if_valid}, 32'h0);
    tick();
    chk("t1_valid_grant_plus2", {31'h0, if_valid}, 32'h1);
    expect_entry("t1_e0", 32'h0, 1'b0);
    expect_entry("t1_e4", 32'h4, 1'b0);
    expect_entry("t1_e8", 32'h8, 1'b0);
    expect_entry("t1_eC", 32'hC, 1'b0);

    // ---------------- 2: backpressure ----------------
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) chk("t2_pc_hold_mid", if_pc, 32'h0);
    end
    chk("t2_grants",   n_gnt, 32'd2);
    chk("t2_req_low",  {31'h0, imem_req}, 32'h0);
    chk("t2_valid",    {31'h0, if_valid}, 32'h1);
    chk("t2_pc_hold",  if_pc, 32'h0);
    chk("t2_instr",    if_instr, 32'hE000_0000);
    if_ready = 1'b1;
    expect_entry("t2_e0", 32'h0, 1'b0);
    expect_entry("t2_e4", 32'h4, 1'b0);
    expect_entry("t2_e8", 32'h8, 1'b0);

    // ---------------- 3: redirect with a request in flight ----------------
    do_reset();
    if_ready = 1'b1;
    rv_delay = 2;
    find_grant("t3_gnt_10", 32'h10);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("t3_flush", {31'h0, if_valid}, 32'h0);
    chk("t3_rvalid_now", {31'h0, imem_rvalid}, 32'h1);
    tick();
    chk("t3_target_req",  {31'h0, imem_req}, 32'h1);
    chk("t3_target_addr", imem_addr, 32'h100);
    expect_entry("t3_e100", 32'h100, 1'b0);
    expect_entry("t3_e104", 32'h104, 1'b0);

    // ---------------- 4: redirect together with rvalid ----------------
    do_reset();
    find_grant("t4_gnt_4", 32'h4);
    tick();
    chk("t4_pre_valid", {31'h0, if_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0202;
    tick();
    redirect_valid = 1'b0;
    chk("t4_flush",       {31'h0, if_valid}, 32'h0);
    chk("t4_target_req",  {31'h0, imem_req}, 32'h1);
    chk("t4_target_addr", imem_addr, 32'h200);
    if_ready = 1'b1;
    expect_entry("t4_e200", 32'h200, 1'b0);

    // ---------------- 5: bus error ----------------
    do_reset();
    if_ready = 1'b1;
    err_en   = 1'b1;
    err_addr = 32'h8;
    expect_entry("t5_e0", 32'h0, 1'b0);
    expect_entry("t5_e4", 32'h4, 1'b0);
    expect_entry("t5_e8", 32'h8, 1'b1);
    expect_entry("t5_eC", 32'hC, 1'b0);

    // ---------------- 6: async reset mid-WAIT ----------------
    do_reset();
    rv_delay = 4;
    find_grant("t6_gnt_4", 32'h4);
    tick();
    chk("t6_pre_valid", {31'h0, if_valid}, 32'h1);
    chk("t6_pre_addr",  imem_addr, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_req",   {31'h0, imem_req}, 32'h0);
    chk("t6_async_addr",  imem_addr, 32'h0);
    chk("t6_async_valid", {31'h0, if_valid}, 32'h0);
    chk("t6_async_instr", if_instr, 32'h0);
    chk("t6_async_pc",    if_pc, 32'h0);
    chk("t6_async_abort", {31'h0, if_abort}, 32'h0);
    tick();
    rst_n     = 1'b1;
    gnt_delay = 3;
    rv_delay  = 1;
    if_ready  = 1'b1;
    expect_entry("t6_e0", 32'h0, 1'b0);
    expect_entry("t6_e4", 32'h4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
